// File: rtl/umi_pack_ser.sv
// umi_pack_ser: latches one UMI command and serialises it as OW-bit beats.
// Header beats (cmd, dstaddr, srcaddr) are always sent. Data beats follow only
// when opcode[0] is set. A new command can be taken on the final-beat
// handshake, so packets can run back to back with no idle cycle.
module umi_pack_ser #(
    parameter int AW = 64,
    parameter int DW = 256,
    parameter int OW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    opcode_in,
    input  logic [3:0]    size_in,
    input  logic [19:0]   user_in,
    input  logic [AW-1:0] dstaddr_in,
    input  logic [AW-1:0] srcaddr_in,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last
);

    localparam int PW = 3*AW + DW;
    localparam int HB = 3*AW/OW;
    localparam int DB = DW/OW;
    localparam int NB = HB + DB;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_HDR = CW'(HB-1);
    localparam logic [CW-1:0] LAST_ALL = CW'(NB-1);

    // The beat slicing below assumes whole beats per field and a 32-bit command word.
    if (OW < 32 || AW < 32 || (AW % OW) != 0 || (DW % OW) != 0) begin : g_bad_params
        $error("umi_pack_ser: illegal AW/DW/OW combination");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          has_data;
    logic [PW-1:0] pkt;
    logic          load;
    logic          advance;
    logic [CW-1:0] last_idx;

    assign last_idx = has_data ? LAST_ALL : LAST_HDR;

    // Control state: FSM, beat counter and data-beat flag of the held packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            has_data <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) has_data <= opcode_in[0];
        end
    end

    // Packet shift register. Beat 0 sits in the low OW bits; each accepted
    // non-final beat shifts the next one down. It is not reset because
    // out_data is forced to zero whenever no beat is valid.
    always_ff @(posedge clk) begin
        if (load) begin
            pkt <= {data_in, srcaddr_in, dstaddr_in, AW'({user_in, size_in, opcode_in})};
        end else if (advance) begin
            pkt <= pkt >> OW;
        end
    end

    // Next state, handshakes and beat sequencing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (cnt == last_idx);
                if (out_ready) begin
                    if (out_last) begin
                        // The final handshake frees the slot, so a waiting command is taken here.
                        in_ready = 1'b1;
                        cnt_nxt  = '0;
                        if (in_valid) load = 1'b1;
                        else          state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            in_ready = 1'b0;
            load     = 1'b0;
        end
    end

    assign out_data = out_valid ? pkt[OW-1:0] : '0;

endmodule

// File: tb/tb_umi_pack_ser.sv
// Bench for umi_pack_ser. Expected beats are pushed into a queue when the
// stimulus is issued. Negedge monitors pop an entry and compare it on each
// beat handshake. A second instance covers the OW=32 geometry.
module tb_umi_pack_ser;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: AW=64, DW=256, OW=64
    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0]   opcode;
    logic [3:0]   size;
    logic [19:0]  user;
    logic [63:0]  dst, src, out_data;
    logic [255:0] data;

    // Instance B: AW=64, DW=128, OW=32
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0]   b_opcode;
    logic [3:0]   b_size;
    logic [19:0]  b_user;
    logic [63:0]  b_dst, b_src;
    logic [127:0] b_data;
    logic [31:0]  b_out_data;

    umi_pack_ser #(.AW(64), .DW(256), .OW(64)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode), .size_in(size), .user_in(user), .dstaddr_in(dst),
        .srcaddr_in(src), .data_in(data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    umi_pack_ser #(.AW(64), .DW(128), .OW(32)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opcode_in(b_opcode), .size_in(b_size), .user_in(b_user), .dstaddr_in(b_dst),
        .srcaddr_in(b_src), .data_in(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last)
    );

    typedef struct {
        logic [63:0] d;
        logic        last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t ma, mb;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_n = 0, first_hs = 0, last_hs = 0;
    int hs_b = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] held_d;
    logic        held_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [63:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.last = l;
        qa.push_back(b);
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        beat_t b;
        b.d = {32'h0, d};
        b.last = l;
        qb.push_back(b);
    endtask

    // Expected beats for instance A, built from the packet layout.
    task automatic push_pkt_a(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] us,
                              input logic [63:0] da, input logic [63:0] sa, input logic [255:0] dd);
        int nb;
        logic [63:0] v;
        nb = op[0] ? 7 : 3;
        for (int k = 0; k < nb; k++) begin
            case (k)
                0:       v = {32'h0, us, sz, op};
                1:       v = da;
                2:       v = sa;
                default: v = dd[(k-3)*64 +: 64];
            endcase
            push_a(v, k == nb-1);
        end
    endtask

    task automatic issue_a(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] us,
                           input logic [63:0] da, input logic [63:0] sa, input logic [255:0] dd);
        int n;
        opcode = op; size = sz; user = us; dst = da; src = sa; data = dd;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_b(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] us,
                           input logic [63:0] da, input logic [63:0] sa, input logic [127:0] dd);
        int n;
        b_opcode = op; b_size = sz; b_user = us; b_dst = da; b_src = sa; b_data = dd;
        b_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) begin
            total++;
            bad++;
            $display("FAIL b_accept_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 64'(qa.size() + qb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor A: hold stability, idle zero, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, held_d);
                chk("hold_last", 64'(out_last), 64'(held_l));
            end
            if (!out_valid) chk("idle_data", out_data, 64'd0);
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want none", out_data);
                end else begin
                    ma = qa.pop_front();
                    chk("beat_data", out_data, ma.d);
                    chk("beat_last", 64'(out_last), 64'(ma.last));
                end
                if (hs_n == 0) first_hs = cyc;
                last_hs = cyc;
                hs_n++;
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
        end
    end

    // Monitor B: idle zero and scoreboard pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (!b_out_valid) chk("b_idle_data", 64'(b_out_data), 64'd0);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_beat: got %h want none", b_out_data);
                end else begin
                    mb = qb.pop_front();
                    chk("b_beat_data", 64'(b_out_data), mb.d);
                    chk("b_beat_last", 64'(b_out_last), 64'(mb.last));
                end
                hs_b++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; size = '0; user = '0; dst = '0; src = '0; data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_opcode = '0; b_size = '0; b_user = '0; b_dst = '0; b_src = '0; b_data = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // 1: write, 7 beats, hand-computed values
        hs_n = 0;
        push_a(64'h00000000_ABCDE803, 1'b0);
        push_a(64'h0000000000001000, 1'b0);
        push_a(64'h0000000000002000, 1'b0);
        push_a(64'h0706050403020100, 1'b0);
        push_a(64'h0F0E0D0C0B0A0908, 1'b0);
        push_a(64'h1716151413121110, 1'b0);
        push_a(64'h1F1E1D1C1B1A1918, 1'b1);
        issue_a(8'h03, 4'h8, 20'hABCDE, 64'h1000, 64'h2000,
                256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100);
        in_valid = 1'b0;
        drain();
        chk("t1_beats", 64'(hs_n), 64'd7);
        chk("t1_span", 64'(last_hs - first_hs), 64'd6);

        // 2: read, header beats only, data ignored
        hs_n = 0;
        push_pkt_a(8'h02, 4'h4, 20'h00F0F, 64'h3000, 64'h4000, '0);
        issue_a(8'h02, 4'h4, 20'h00F0F, 64'h3000, 64'h4000, {8{32'hFFFF_FFFF}});
        in_valid = 1'b0;
        drain();
        chk("t2_beats", 64'(hs_n), 64'd3);

        // 3: out_ready toggling 1/0, 13 cycles, in_ready low until last handshake
        hs_n = 0;
        out_ready = 1'b0;
        push_pkt_a(8'h11, 4'h2, 20'h55555, 64'hAAAA_0000_1111_2222, 64'h3333_4444_5555_6666,
                   256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7);
        issue_a(8'h11, 4'h2, 20'h55555, 64'hAAAA_0000_1111_2222, 64'h3333_4444_5555_6666,
                256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7);
        in_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            out_ready = (c % 2) == 1;
            @(negedge clk);
            chk("t3_in_ready", 64'(in_ready), 64'(c == 13));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("t3_beats", 64'(hs_n), 64'd7);
        chk("t3_span", 64'(last_hs - first_hs), 64'd12);

        // 4: back-to-back writes with in_valid held high
        hs_n = 0;
        push_pkt_a(8'h03, 4'h1, 20'h11111, 64'h10, 64'h20,
                   256'h4_0000000000000003_0000000000000002_0000000000000001);
        push_pkt_a(8'h05, 4'h3, 20'h22222, 64'h30, 64'h40,
                   256'h8_0000000000000007_0000000000000006_0000000000000005);
        issue_a(8'h03, 4'h1, 20'h11111, 64'h10, 64'h20,
                256'h4_0000000000000003_0000000000000002_0000000000000001);
        issue_a(8'h05, 4'h3, 20'h22222, 64'h30, 64'h40,
                256'h8_0000000000000007_0000000000000006_0000000000000005);
        in_valid = 1'b0;
        drain();
        chk("t4_beats", 64'(hs_n), 64'd14);
        chk("t4_span", 64'(last_hs - first_hs), 64'd13);

        // 5: reset on beat 3 of a write, then a clean read
        push_pkt_a(8'h07, 4'h8, 20'h0BEEF, 64'h50, 64'h60, {4{64'h5A5A_5A5A_5A5A_5A5A}});
        issue_a(8'h07, 4'h8, 20'h0BEEF, 64'h50, 64'h60, {4{64'h5A5A_5A5A_5A5A_5A5A}});
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_data", out_data, 64'd0);
        chk("t5_out_last", 64'(out_last), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        hs_n = 0;
        push_pkt_a(8'h02, 4'h2, 20'h00123, 64'h70, 64'h80, '0);
        issue_a(8'h02, 4'h2, 20'h00123, 64'h70, 64'h80, '0);
        in_valid = 1'b0;
        drain();
        chk("t5_beats", 64'(hs_n), 64'd3);

        // 6: OW=32 instance, 6 header + 4 data beats
        hs_b = 0;
        push_b(32'h12345401, 1'b0);
        push_b(32'h00000000, 1'b0);
        push_b(32'h00000ABC, 1'b0);
        push_b(32'h00000001, 1'b0);
        push_b(32'hCAFEF00D, 1'b0);
        push_b(32'hDEADBEEF, 1'b0);
        push_b(32'h11111111, 1'b0);
        push_b(32'h22222222, 1'b0);
        push_b(32'h33333333, 1'b0);
        push_b(32'h44444444, 1'b1);
        issue_b(8'h01, 4'h4, 20'h12345, 64'h0000_0001_0000_0ABC, 64'hDEAD_BEEF_CAFE_F00D,
                128'h44444444_33333333_22222222_11111111);
        drain();
        chk("t6_beats", 64'(hs_b), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
